writeback_buffer: RTL

//  Single-entry eviction buffer between the cache controller/data array and physical memory.

---
 rtl/writeback_buffer_if.sv | 43 ++++
 rtl/writeback_buffer.sv | 119 +++++++++++
 2 files changed

// File: rtl/writeback_buffer_if.sv
// Bundle of the writeback buffer's handshake and memory signals.
//   evict_*  : victim line hand-off from the cache controller (valid/ready)
//   fill_*   : line-fill request/grant from the controller
//   fwd_*    : forwarding of the buffered line on a fill hit
//   pmem_*   : write port toward physical memory
//   busy     : buffer holds a line
//   state_dbg: current buffer state, for observation only
// Modports: slave = the buffer, master = controller / memory side.
//
// Handshake semantics: a victim transfers on the rising clk edge where
// evict_valid && evict_ready; the controller keeps evict_valid, evict_addr and
// evict_data stable until that edge. fill_req is held high until the fill is
// done; fill_grant and fwd_hit are combinational answers in the same cycle.
// pmem_write is held with stable address/data until the pmem_resp edge.
interface writeback_buffer_if;
  logic         evict_valid;
  logic         evict_ready;
  logic [15:0]  evict_addr;
  logic [127:0] evict_data;
  logic         fill_req;
  logic [15:0]  fill_addr;
  logic         fill_grant;
  logic         fwd_hit;
  logic [127:0] fwd_data;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic         busy;
  logic [1:0]   state_dbg;

  modport slave (
    input  evict_valid, evict_addr, evict_data, fill_req, fill_addr, pmem_resp,
    output evict_ready, fill_grant, fwd_hit, fwd_data, pmem_write,
           pmem_address, pmem_wdata, busy, state_dbg
  );

  modport master (
    output evict_valid, evict_addr, evict_data, fill_req, fill_addr, pmem_resp,
    input  evict_ready, fill_grant, fwd_hit, fwd_data, pmem_write,
           pmem_address, pmem_wdata, busy, state_dbg
  );
endinterface

// File: rtl/writeback_buffer.sv
// Single-entry eviction buffer between the cache and physical memory.
// A dirty victim is captured in one cycle so the cache can start its fill
// immediately; the victim is written to pmem once the memory port is idle.
// Fills have priority, and a fill to the buffered line is forwarded.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : writeback_buffer_if.slave (evict, fill, forward, pmem, busy)
// MAX_DEFER: fills granted while FULL before further fills are held off
//            and the drain is forced.
module writeback_buffer #(
  parameter int MAX_DEFER = 16
) (
  input  logic               clk,
  input  logic               reset,
  writeback_buffer_if.slave  bus
);

  localparam int CW = $clog2(MAX_DEFER + 1);
  localparam logic [CW-1:0] DEFER_MAX = CW'(MAX_DEFER);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [11:0]   buf_addr_q, buf_addr_d;   // line tag, addr[15:4]
  logic [127:0]  buf_data_q, buf_data_d;
  logic          fill_active_q, fill_active_d;
  logic [CW-1:0] defer_cnt_q, defer_cnt_d;

  logic fwd_hit;
  logic fill_grant;

  // Offset bits of the addresses carry no information for a line buffer.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.evict_addr[3:0], bus.fill_addr[3:0]};

  always_comb begin
    fwd_hit    = (state_q != S_EMPTY) && bus.fill_req &&
                 (bus.fill_addr[15:4] == buf_addr_q);
    fill_grant = 1'b0;
    case (state_q)
      S_EMPTY: fill_grant = 1'b1;
      S_FULL:  fill_grant = !fwd_hit && !fill_active_q && (defer_cnt_q < DEFER_MAX);
      default: fill_grant = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    buf_addr_d    = buf_addr_q;
    buf_data_d    = buf_data_q;
    defer_cnt_d   = defer_cnt_q;
    // A fill stays active until the controller drops fill_req.
    fill_active_d = bus.fill_req && (fill_active_q || (fill_grant && !fwd_hit));

    // Count fills that start while a victim is waiting, so a steady stream of
    // fills cannot starve the drain forever.
    if ((state_q == S_FULL) && !fill_active_q && fill_active_d &&
        (defer_cnt_q < DEFER_MAX)) begin
      defer_cnt_d = defer_cnt_q + 1'b1;
    end

    case (state_q)
      S_EMPTY: begin
        if (bus.evict_valid) begin
          buf_addr_d = bus.evict_addr[15:4];
          buf_data_d = bus.evict_data;
          state_d    = S_FULL;
        end
      end
      S_FULL: begin
        // Only start the drain when no fill owns pmem, so pmem_resp is ours.
        if (!fill_active_q && !(bus.fill_req && fill_grant)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.pmem_resp) begin
          state_d     = S_EMPTY;
          defer_cnt_d = '0;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_EMPTY;
      buf_addr_q    <= '0;
      buf_data_q    <= '0;
      fill_active_q <= 1'b0;
      defer_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      buf_addr_q    <= buf_addr_d;
      buf_data_q    <= buf_data_d;
      fill_active_q <= fill_active_d;
      defer_cnt_q   <= defer_cnt_d;
    end
  end

  // Memory-side outputs decode directly from the state flop, so they drop
  // the moment reset is asserted.
  assign bus.evict_ready  = (state_q == S_EMPTY);
  assign bus.busy         = (state_q != S_EMPTY);
  assign bus.pmem_write   = (state_q == S_DRAIN);
  assign bus.pmem_address = (state_q == S_DRAIN) ? {buf_addr_q, 4'b0000} : 16'h0000;
  assign bus.pmem_wdata   = (state_q == S_DRAIN) ? buf_data_q : '0;
  assign bus.fwd_hit      = fwd_hit;
  assign bus.fwd_data     = fwd_hit ? buf_data_q : '0;
  assign bus.fill_grant   = fill_grant;
  assign bus.state_dbg    = state_q;

endmodule
